ps2_key_receiver: RTL and testbench
===================================

Name: ps2_key_receiver

Overview:
- Upstream stage of the cursor/command logic in the chess top level.
- Receives the raw PS/2 keyboard clock/data lines, deframes 11-bit device-to-host frames and checks start/parity/stop.
- Folds the E0 (extended) and F0 (break) prefix bytes into one 11-bit key_event word.
- The top level edge-detects key_event to move the cursor and raise select/promotion requests.

Parameters:
- FILTER_LEN, 8: consecutive equal samples required before the filtered ps2_c level changes.
- TIMEOUT_CYCLES, 100000: clk cycles with no ps2_c falling edge, mid-frame, before the frame is aborted (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz.
- rstn  input  1  reset, synchronous, active-low.
- ps2_c  input  1  raw PS/2 clock line, asynchronous.
- ps2_d  input  1  raw PS/2 data line, asynchronous.
- key_event  output  11  [10]=valid (a complete event has been received since reset), [9]=extended, [8]=break/release, [7:0]=scan code. Holds the last event.
- key_strobe  output  1  one-cycle pulse when key_event is updated.
- frame_err  output  1  one-cycle pulse on parity/start/stop error or timeout.

Behaviour:
- Reset (rstn=0 at a clk edge): key_event=0, key_strobe=0, frame_err=0, FSM=IDLE, bit count=0, ext/brk flags=0, timeout counter=0, sync registers=1, filter output=1.
- Input conditioning:
  - ps2_c and ps2_d each pass through a 2-FF synchroniser.
  - Synchronised ps2_c feeds a saturating filter. The filtered level flips only after FILTER_LEN consecutive samples differ from it.
  - A falling edge is filtered level 1 then 0. It produces fall_tick for one cycle.
  - Data is the synchronised ps2_d sampled in the fall_tick cycle.
- Frame FSM, states IDLE, RECV, CHECK:
  - IDLE: on fall_tick, capture the start bit and go to RECV with bit count=1.
  - RECV: on each fall_tick, shift data in LSB-first (bits 1-8 data, bit 9 parity, bit 10 stop) and increment the count. On the fall_tick capturing bit 10, go to CHECK.
  - CHECK (exactly one cycle): the frame is valid iff start=0, stop=1 and XOR(data, parity)=1 (odd parity). Always return to IDLE.
  - Invalid frame: frame_err=1 for the next cycle, byte discarded, ext and brk cleared, key_event unchanged.
- Byte decode of a valid byte B in CHECK:
  - B=0xE0: set ext.
  - B=0xF0: set brk.
  - B=0xE1: dropped, flags unchanged.
  - Any other B: key_event <= {1, ext, brk, B}, key_strobe=1 for one cycle, ext and brk cleared.
  - Outputs register on the cycle after CHECK, i.e. 2 clk cycles after the fall_tick of the stop bit.
- Timeout:
  - In RECV, the counter increments every cycle without fall_tick and clears on fall_tick.
  - When the count reaches TIMEOUT_CYCLES: go to IDLE, frame_err pulse, partial frame discarded, ext and brk cleared.
  - The counter is held at 0 in IDLE. A prefix byte followed by a long idle gap stays pending (no timeout in IDLE).
- Typematic repeats of a held key: each repeat produces a fresh key_strobe with an identical key_event. Suppressing repeats is the consumer's job.
- A fall_tick in CHECK cannot occur, since PS/2 bit periods are at least 60 µs. If one does occur, it is ignored.
- key_strobe and frame_err never assert in the same cycle.
- The block never drives the PS/2 lines (receive only).

Test Plan:
1. Send frame 0x1D (W make; 10 kHz PS/2 clock, correct odd parity) -> one key_strobe, key_event=0x41D, frame_err stays 0; strobe lands 2 cycles after the stop-bit fall_tick.
2. Send F0 then 1D -> one strobe only (none for the F0), key_event=0x51D. Then send E0 75 -> key_event=0x675. Then send E0 F0 75 -> key_event=0x775, with exactly 3 strobes total across the sequence.
3. Send 0x29 with the parity bit inverted -> frame_err pulses once, no strobe, key_event keeps its prior value. A following good 0x29 -> key_event=0x429.
4. Send start + 4 data bits, then hold ps2_c high -> frame_err pulses TIMEOUT_CYCLES±2 cycles after the last edge. A following complete 0x1C frame -> key_event=0x41C.
5. Inject a 3-cycle low glitch on ps2_c while idle, and a 5-cycle glitch mid-frame, then complete a 0x42 frame -> no spurious bit captured, key_event=0x442.
6. Assert rstn=0 for one cycle after the 6th bit of a frame, then send a complete 0x4B -> key_event=0 immediately after reset, then 0x44B with ext=brk=0. Also send E0 then reset then 0x75 -> key_event=0x475 (ext cleared by reset).

Source files
------------

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: conditions the raw clock/data lines, deframes 11-bit frames
// and folds the E0/F0 prefixes into a single key_event word with a strobe.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ps2_c,
  input  logic        ps2_d,
  output logic [10:0] key_event,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic          c_s1, c_s2, d_s1, d_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt_lvl, filt_prev;
  logic          fall_tick;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [10:0]   shreg;
  logic [TW-1:0] to_cnt;
  logic          ext, brk;
  logic          frame_ok;
  logic [7:0]    rx_byte;

  // Synchronisers idle high so a line held high through reset never looks like an edge.
  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2_c;
      c_s2 <= c_s1;
      d_s1 <= ps2_d;
      d_s2 <= d_s1;
    end
  end

  // The filtered level only follows after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      filt_cnt  <= '0;
      filt_lvl  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_lvl;
      if (c_s2 == filt_lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_lvl <= c_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall_tick = filt_prev & ~filt_lvl;

  // After eleven LSB-first shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign rx_byte  = shreg[8:1];
  assign frame_ok = ~shreg[0] & shreg[10] & (^shreg[9:1]);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      key_event  <= '0;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall_tick) begin
            shreg   <= {d_s2, shreg[10:1]};
            bit_cnt <= 4'd1;
            state   <= RECV;
          end
        end
        RECV: begin
          if (fall_tick) begin
            shreg   <= {d_s2, shreg[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
            to_cnt  <= '0;
            if (bit_cnt == 4'd10) state <= CHECK;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b1;
            ext       <= 1'b0;
            brk       <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          bit_cnt <= '0;
          to_cnt  <= '0;
          if (!frame_ok) begin
            frame_err <= 1'b1;
            ext       <= 1'b0;
            brk       <= 1'b0;
          end else if (rx_byte == 8'hE0) begin
            ext <= 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk <= 1'b1;
          end else if (rx_byte != 8'hE1) begin
            key_event  <= {1'b1, ext, brk, rx_byte};
            key_strobe <= 1'b1;
            ext        <= 1'b0;
            brk        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed and randomized frames against a byte-level model of the PS/2 prefix rules;
// the PS/2 clock is scaled down and the timeout shortened to keep the run short.
module tb_ps2_key_receiver;

  localparam int FILT = 8;
  localparam int TO   = 1000;
  localparam int HALF = 40;
  localparam int GAP  = 60;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ps2_c = 1'b1;
  logic        ps2_d = 1'b1;
  logic [10:0] key_event;
  logic        key_strobe;
  logic        frame_err;

  ps2_key_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .ps2_c(ps2_c), .ps2_d(ps2_d),
    .key_event(key_event), .key_strobe(key_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int strobe_cnt = 0, err_cnt = 0, overlap = 0;
  int fall_cyc = 0, strobe_cyc = 0, err_cyc = 0;
  int vectors = 0, miscompares = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dut.fall_tick) fall_cyc = cyc;
    if (key_strobe) begin strobe_cnt++; strobe_cyc = cyc; end
    if (frame_err)  begin err_cnt++;    err_cyc = cyc;    end
    if (key_strobe && frame_err) overlap++;
  end

  // Reference model: byte-level prefix folding and cumulative pulse counts.
  logic [10:0] m_event = '0;
  logic        m_ext = 1'b0, m_brk = 1'b0;
  int          m_strobes = 0, m_errs = 0;

  task automatic model_frame(input logic [7:0] b, input int err_kind);
    if (err_kind != 0) begin
      m_errs++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b != 8'hE1) begin
      m_event = {1'b1, m_ext, m_brk, b};
      m_strobes++; m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_event = '0; m_ext = 1'b0; m_brk = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // err_kind: 0 good, 1 parity flipped, 2 start=1, 3 stop=0. nbits < 11 sends a partial frame.
  task automatic send_frame(input logic [7:0] b, input int err_kind, input int nbits,
                            input int glitch_bit);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (err_kind == 1) f[9]  = ~f[9];
    if (err_kind == 2) f[0]  = 1'b1;
    if (err_kind == 3) f[10] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      ps2_d = f[i];
      if (i == glitch_bit) begin
        wait_cyc(10); ps2_c = 1'b0; wait_cyc(5); ps2_c = 1'b1; wait_cyc(HALF - 15);
      end else begin
        wait_cyc(HALF);
      end
      ps2_c = 1'b0;
      wait_cyc(HALF);
      ps2_c = 1'b1;
    end
    ps2_d = 1'b1;
  endtask

  task automatic frame_step(input string tag, input logic [7:0] b, input int err_kind);
    send_frame(b, err_kind, 11, -1);
    model_frame(b, err_kind);
    wait_cyc(GAP);
    check({tag, "_event"},   32'(key_event), 32'(m_event));
    check({tag, "_strobes"}, 32'(strobe_cnt), 32'(m_strobes));
    check({tag, "_errs"},    32'(err_cnt), 32'(m_errs));
  endtask

  initial begin
    int diff;
    logic [7:0] rb;
    int ek;

    // Reset state
    wait_cyc(3);
    check("reset_event",  32'(key_event), 32'h0);
    check("reset_strobe", 32'(key_strobe), 32'h0);
    check("reset_err",    32'(frame_err), 32'h0);
    rstn = 1'b1;
    wait_cyc(20);

    // 1: plain make code, strobe two cycles after the stop-bit fall_tick
    frame_step("w_make", 8'h1D, 0);
    check("w_make_latency", 32'(strobe_cyc - fall_cyc), 32'd2);

    // 2: break and extended prefixes
    frame_step("f0", 8'hF0, 0);
    frame_step("w_brk", 8'h1D, 0);
    frame_step("e0", 8'hE0, 0);
    frame_step("up_ext", 8'h75, 0);
    frame_step("e0b", 8'hE0, 0);
    frame_step("f0b", 8'hF0, 0);
    frame_step("up_ext_brk", 8'h75, 0);

    // 3: bad parity leaves key_event alone, then a good frame
    frame_step("bad_par", 8'h29, 1);
    frame_step("good_29", 8'h29, 0);

    // 4: partial frame then silence -> timeout
    send_frame(8'h1C, 0, 5, -1);
    wait_cyc(TO + 100);
    model_frame(8'h00, 4);
    check("to_errs", 32'(err_cnt), 32'(m_errs));
    diff = err_cyc - fall_cyc;
    check("to_window", 32'(diff >= TO - 2 && diff <= TO + 2), 32'd1);
    check("to_event", 32'(key_event), 32'(m_event));
    frame_step("after_to", 8'h1C, 0);

    // 5: glitches on ps2_c while idle and mid-frame
    ps2_c = 1'b0; wait_cyc(3); ps2_c = 1'b1; wait_cyc(30);
    send_frame(8'h42, 0, 11, 4);
    model_frame(8'h42, 0);
    wait_cyc(GAP);
    check("glitch_event",   32'(key_event), 32'(m_event));
    check("glitch_strobes", 32'(strobe_cnt), 32'(m_strobes));
    check("glitch_errs",    32'(err_cnt), 32'(m_errs));

    // 6: reset mid-frame, and reset clearing a pending E0
    frame_step("pre_e0", 8'hE0, 0);
    send_frame(8'h4B, 0, 6, -1);
    wait_cyc(5);
    rstn = 1'b0; wait_cyc(1); rstn = 1'b1;
    model_reset();
    check("rst_event", 32'(key_event), 32'h0);
    wait_cyc(30);
    frame_step("post_rst", 8'h4B, 0);
    frame_step("e0_again", 8'hE0, 0);
    rstn = 1'b0; wait_cyc(1); rstn = 1'b1;
    model_reset();
    wait_cyc(30);
    frame_step("ext_cleared", 8'h75, 0);

    // Randomized frames: prefixes, E1, arbitrary bytes, occasional framing errors
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    rb = 8'hE0;
        2, 3:    rb = 8'hF0;
        4:       rb = 8'hE1;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      ek = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      frame_step($sformatf("rand%0d_%02h_k%0d", n, rb, ek), rb, ek);
    end

    check("no_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
